// File: rtl/geofence_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | geofence_pkg                                                     |
// | Shared types and sizing helpers for the polygon geofence block.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package geofence_pkg;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        SORT = 2'd1,
        TEST = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        ZERO = 2'b00,
        POS  = 2'b01,
        NEG  = 2'b10
    } sign_t;

    function automatic int cross_width(input int w);
        return 2 * w + 3;
    endfunction

    function automatic int count_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/geofence_cross.sv
`default_nettype none
// +------------------------------------------------------------------+
// | geofence_cross                                                   |
// | Sign of the 2-D cross product a x b for W+1-bit signed vectors.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module geofence_cross
    import geofence_pkg::*;
#(
    parameter int W = 10
) (
    input  logic signed [W:0] i_ax,
    input  logic signed [W:0] i_ay,
    input  logic signed [W:0] i_bx,
    input  logic signed [W:0] i_by,
    output logic [1:0]        o_sgn
);

    localparam int c_pw = 2 * W + 2;
    localparam int c_cw = cross_width(W);

    logic signed [c_pw-1:0] w_p1;
    logic signed [c_pw-1:0] w_p2;
    logic signed [c_cw-1:0] w_diff;

    always_comb begin
        w_p1   = c_pw'(i_ax) * c_pw'(i_by);
        w_p2   = c_pw'(i_ay) * c_pw'(i_bx);
        w_diff = c_cw'(w_p1) - c_cw'(w_p2);
        if (w_diff[c_cw-1]) begin
            o_sgn = NEG;
        end else if (w_diff == '0) begin
            o_sgn = ZERO;
        end else begin
            o_sgn = POS;
        end
    end

endmodule
`default_nettype wire

// File: rtl/geofence_poly.sv
`default_nettype none
// +------------------------------------------------------------------+
// | geofence_poly                                                    |
// | Loads a target and N vertices, sorts them CCW about v0, then     |
// | tests the target against every edge with one shared cross unit.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module geofence_poly
    import geofence_pkg::*;
#(
    parameter int N            = 6,
    parameter int W            = 10,
    parameter bit INCLUDE_EDGE = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [W-1:0] X,
    input  logic [W-1:0] Y,
    output logic         busy,
    output logic         valid,
    output logic         is_inside,
    output logic         on_edge
);

    localparam int                c_cw     = count_width(N);
    localparam int                c_iw     = $clog2(N);
    localparam logic [c_cw-1:0]   c_last   = c_cw'(N);
    localparam logic [c_cw-1:0]   c_cnt1   = c_cw'(1);
    localparam logic [c_iw-1:0]   c_one    = c_iw'(1);
    localparam logic [c_iw-1:0]   c_kmax   = c_iw'(N - 2);
    localparam logic [c_iw-1:0]   c_pmax   = c_iw'(N - 3);
    localparam logic [c_iw-1:0]   c_emax   = c_iw'(N - 1);

    state_t             r_state;
    state_t             w_next;
    logic [c_cw-1:0]    r_cnt;
    logic [c_iw-1:0]    r_k;
    logic [c_iw-1:0]    r_pass;
    logic [c_iw-1:0]    r_e;
    logic [c_iw-1:0]    w_k1;
    logic [c_iw-1:0]    w_e1;
    logic [c_iw-1:0]    w_ld_idx;
    logic               w_capture;
    logic [W-1:0]       r_tx;
    logic [W-1:0]       r_ty;
    logic [W-1:0]       r_vx [N];
    logic [W-1:0]       r_vy [N];
    logic signed [W:0]  w_ax;
    logic signed [W:0]  w_ay;
    logic signed [W:0]  w_bx;
    logic signed [W:0]  w_by;
    logic [1:0]         w_sgn;
    logic               r_all_pos;
    logic               r_all_nonneg;
    logic               r_any_zero;
    logic               r_busy;
    logic               r_valid;
    logic               r_is_inside;
    logic               r_on_edge;

    // Zero-extend both points before subtracting so the difference never wraps.
    function automatic logic signed [W:0] rel(input logic [W-1:0] p, input logic [W-1:0] o);
        return $signed({1'b0, p}) - $signed({1'b0, o});
    endfunction

    assign w_ld_idx = c_iw'(r_cnt - c_cnt1);

    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        case (r_state)
            LOAD: begin
                if (in_valid) begin
                    w_capture = 1'b1;
                    if (r_cnt == c_last) begin
                        w_next = SORT;
                    end
                end
            end
            SORT:    if (r_k == c_kmax && r_pass == c_pmax) w_next = TEST;
            TEST:    if (r_e == c_emax) w_next = DONE;
            DONE:    w_next = LOAD;
            default: w_next = LOAD;
        endcase
    end

    // SORT compares (vk, vk+1) about v0; TEST compares edge e against the target.
    always_comb begin
        w_k1 = r_k + c_one;
        w_e1 = (r_e == c_emax) ? '0 : r_e + c_one;
        if (r_state == TEST) begin
            w_ax = rel(r_vx[w_e1], r_vx[r_e]);
            w_ay = rel(r_vy[w_e1], r_vy[r_e]);
            w_bx = rel(r_tx, r_vx[r_e]);
            w_by = rel(r_ty, r_vy[r_e]);
        end else begin
            w_ax = rel(r_vx[r_k], r_vx[0]);
            w_ay = rel(r_vy[r_k], r_vy[0]);
            w_bx = rel(r_vx[w_k1], r_vx[0]);
            w_by = rel(r_vy[w_k1], r_vy[0]);
        end
    end

    geofence_cross #(
        .W (W)
    ) u_cross (
        .i_ax  (w_ax),
        .i_ay  (w_ay),
        .i_bx  (w_bx),
        .i_by  (w_by),
        .o_sgn (w_sgn)
    );

    always_ff @(posedge clk) begin
        if (w_capture) begin
            if (r_cnt == '0) begin
                r_tx <= X;
                r_ty <= Y;
            end else begin
                r_vx[w_ld_idx] <= X;
                r_vy[w_ld_idx] <= Y;
            end
        end else if (r_state == SORT && w_sgn == NEG) begin
            r_vx[r_k]  <= r_vx[w_k1];
            r_vy[r_k]  <= r_vy[w_k1];
            r_vx[w_k1] <= r_vx[r_k];
            r_vy[w_k1] <= r_vy[r_k];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= LOAD;
            r_cnt        <= '0;
            r_k          <= c_one;
            r_pass       <= '0;
            r_e          <= '0;
            r_all_pos    <= 1'b1;
            r_all_nonneg <= 1'b1;
            r_any_zero   <= 1'b0;
            r_busy       <= 1'b0;
            r_valid      <= 1'b0;
            r_is_inside  <= 1'b0;
            r_on_edge    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != LOAD);
            r_valid <= (r_state == DONE);
            case (r_state)
                LOAD: begin
                    r_k          <= c_one;
                    r_pass       <= '0;
                    r_e          <= '0;
                    r_all_pos    <= 1'b1;
                    r_all_nonneg <= 1'b1;
                    r_any_zero   <= 1'b0;
                    if (w_capture) begin
                        r_cnt <= (r_cnt == c_last) ? '0 : r_cnt + c_cnt1;
                    end
                end
                SORT: begin
                    if (r_k == c_kmax) begin
                        r_k    <= c_one;
                        r_pass <= r_pass + c_one;
                    end else begin
                        r_k <= w_k1;
                    end
                end
                TEST: begin
                    r_e          <= w_e1;
                    r_all_pos    <= r_all_pos & (w_sgn == POS);
                    r_all_nonneg <= r_all_nonneg & (w_sgn != NEG);
                    r_any_zero   <= r_any_zero | (w_sgn == ZERO);
                end
                DONE: begin
                    r_is_inside <= r_all_pos | (INCLUDE_EDGE & r_all_nonneg);
                    r_on_edge   <= r_all_nonneg & r_any_zero;
                    r_cnt       <= '0;
                end
                default: ;
            endcase
        end
    end

    assign busy      = r_busy;
    assign valid     = r_valid;
    assign is_inside = r_is_inside;
    assign on_edge   = r_on_edge;

endmodule
`default_nettype wire

// File: tb/tb_geofence_poly.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_geofence_poly                                                 |
// | Scoreboard bench: N=6 (edge excl/incl) and N=4 instances.        |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_geofence_poly;

    localparam int c_w = 10;

    typedef struct {
        bit ins;
        bit edg;
        int cyc;
    } exp_t;

    logic           clk   = 1'b0;
    logic           reset = 1'b1;
    logic           iv6   = 1'b0;
    logic           iv4   = 1'b0;
    logic [c_w-1:0] X     = '0;
    logic [c_w-1:0] Y     = '0;
    logic [2:0]     busy_o;
    logic [2:0]     valid_o;
    logic [2:0]     ins_o;
    logic [2:0]     edge_o;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   fx [17];
    int   fy [17];
    int   cx [16];
    int   cy [16];
    exp_t q0 [$];
    exp_t q1 [$];
    exp_t q2 [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    geofence_poly #(.N(6), .W(c_w), .INCLUDE_EDGE(1'b0)) dut6 (
        .clk(clk), .reset(reset), .in_valid(iv6), .X(X), .Y(Y),
        .busy(busy_o[0]), .valid(valid_o[0]), .is_inside(ins_o[0]), .on_edge(edge_o[0]));

    geofence_poly #(.N(6), .W(c_w), .INCLUDE_EDGE(1'b1)) dut6e (
        .clk(clk), .reset(reset), .in_valid(iv6), .X(X), .Y(Y),
        .busy(busy_o[1]), .valid(valid_o[1]), .is_inside(ins_o[1]), .on_edge(edge_o[1]));

    geofence_poly #(.N(4), .W(c_w), .INCLUDE_EDGE(1'b0)) dut4 (
        .clk(clk), .reset(reset), .in_valid(iv4), .X(X), .Y(Y),
        .busy(busy_o[2]), .valid(valid_o[2]), .is_inside(ins_o[2]), .on_edge(edge_o[2]));

    function automatic int qsize(input int id);
        case (id)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic exp_t qfront(input int id);
        case (id)
            0:       return q0[0];
            1:       return q1[0];
            default: return q2[0];
        endcase
    endfunction

    function automatic void qpop(input int id);
        exp_t e;
        case (id)
            0:       e = q0.pop_front();
            1:       e = q1.pop_front();
            default: e = q2.pop_front();
        endcase
    endfunction

    function automatic void qpush(input int id, input exp_t e);
        case (id)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endfunction

    function automatic longint xp(input longint ax, input longint ay, input longint bx, input longint by);
        return ax * by - ay * bx;
    endfunction

    // Reference: rank each vertex by how many others precede it CCW about v0,
    // then classify the target against the resulting edge loop.
    function automatic void model(input int n, input bit ie, output bit ins, output bit edg);
        longint px [16];
        longint py [16];
        longint c;
        bit     ap;
        bit     an;
        bit     az;
        int     r;
        int     f;
        ap = 1'b1;
        an = 1'b1;
        az = 1'b0;
        px[0] = fx[1];
        py[0] = fy[1];
        for (int j = 2; j <= n; j++) begin
            r = 1;
            for (int i = 2; i <= n; i++) begin
                if (i != j && xp(fx[i] - fx[1], fy[i] - fy[1], fx[j] - fx[1], fy[j] - fy[1]) > 0) r++;
            end
            px[r] = fx[j];
            py[r] = fy[j];
        end
        for (int e = 0; e < n; e++) begin
            f = (e + 1) % n;
            c = xp(px[f] - px[e], py[f] - py[e], fx[0] - px[e], fy[0] - py[e]);
            ap = ap & (c > 0);
            an = an & (c >= 0);
            az = az | (c == 0);
        end
        ins = ap | (ie & an);
        edg = an & az;
    endfunction

    task automatic chk(input string name, input logic got, input logic want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0b want=%0b", name, got, want);
        end
    endtask

    task automatic mon(input int id);
        exp_t e;
        if (valid_o[id]) begin
            total++;
            if (qsize(id) == 0) begin
                bad++;
                $display("FAIL spurious_valid dut%0d cyc=%0d got valid=1 want none", id, cyc);
            end else begin
                e = qfront(id);
                qpop(id);
                if (ins_o[id] !== e.ins || edge_o[id] !== e.edg || cyc != e.cyc) begin
                    bad++;
                    $display("FAIL result dut%0d got inside=%0b edge=%0b cyc=%0d want inside=%0b edge=%0b cyc=%0d",
                             id, ins_o[id], edge_o[id], cyc, e.ins, e.edg, e.cyc);
                end
            end
        end else if (qsize(id) != 0) begin
            e = qfront(id);
            if (cyc > e.cyc) begin
                total++;
                bad++;
                qpop(id);
                $display("FAIL missed_valid dut%0d got no pulse by cyc=%0d want pulse at cyc=%0d", id, cyc, e.cyc);
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int id = 0; id < 3; id++) mon(id);
        end
    end

    task automatic set_iv(input bit g4, input bit v);
        if (g4) iv4 = v;
        else    iv6 = v;
    endtask

    task automatic drive_frame(input bit g4, input int n, input bit gaps, output int cap);
        logic [5:0] pat;
        int         s;
        int         p;
        pat = 6'b101001;
        s   = 0;
        p   = 0;
        while (s <= n) begin
            @(negedge clk);
            if (!gaps || pat[p % 6]) begin
                set_iv(g4, 1'b1);
                X = c_w'(fx[s]);
                Y = c_w'(fy[s]);
                s++;
            end else begin
                set_iv(g4, 1'b0);
            end
            p++;
        end
        cap = cyc + 1;
    endtask

    task automatic finish_frame(input bit g4, input int n, input int cap, input bit garbage);
        int   lat;
        int   cnt;
        bit   ins;
        bit   edg;
        bit   done;
        exp_t e;
        lat  = (n - 2) * (n - 2) + n + 1;
        cnt  = 0;
        done = 1'b0;
        if (g4) begin
            model(n, 1'b0, ins, edg);
            e = '{ins: ins, edg: edg, cyc: cap + lat};
            qpush(2, e);
        end else begin
            model(n, 1'b0, ins, edg);
            e = '{ins: ins, edg: edg, cyc: cap + lat};
            qpush(0, e);
            model(n, 1'b1, ins, edg);
            e = '{ins: ins, edg: edg, cyc: cap + lat};
            qpush(1, e);
        end
        for (int t = 0; t < 400 && !done; t++) begin
            @(negedge clk);
            if (busy_o[g4 ? 2 : 0]) begin
                cnt++;
                set_iv(g4, garbage ? 1'($urandom_range(1, 0)) : 1'b0);
                X = c_w'($urandom);
                Y = c_w'($urandom);
            end else begin
                set_iv(g4, 1'b0);
                done = 1'b1;
            end
        end
        total++;
        if (cnt != lat) begin
            bad++;
            $display("FAIL busy_len got=%0d want=%0d", cnt, lat);
        end
    endtask

    task automatic set_hex(input int tx, input int ty);
        fx[0] = tx;  fy[0] = ty;
        fx[1] = 300; fy[1] = 100;
        fx[2] = 100; fy[2] = 0;
        fx[3] = 100; fy[3] = 200;
        fx[4] = 200; fy[4] = 200;
        fx[5] = 0;   fy[5] = 100;
        fx[6] = 200; fy[6] = 0;
    endtask

    task automatic set_sq(input int tx, input int ty);
        fx[0] = tx;   fy[0] = ty;
        fx[1] = 1023; fy[1] = 1023;
        fx[2] = 0;    fy[2] = 0;
        fx[3] = 0;    fy[3] = 1023;
        fx[4] = 1023; fy[4] = 0;
    endtask

    // Distinct points on a circle form a strictly convex polygon in any order.
    task automatic rand_poly(input int n);
        int slot [16];
        int j;
        int tmp;
        for (int i = 0; i < 16; i++) slot[i] = i;
        for (int i = 15; i > 0; i--) begin
            j       = int'($urandom_range(i, 0));
            tmp     = slot[i];
            slot[i] = slot[j];
            slot[j] = tmp;
        end
        for (int i = 0; i < n; i++) begin
            fx[i + 1] = cx[slot[i]];
            fy[i + 1] = cy[slot[i]];
        end
        if ($urandom_range(3, 0) == 0) begin
            j     = int'($urandom_range(n, 1));
            fx[0] = fx[j];
            fy[0] = fy[j];
        end else begin
            fx[0] = int'($urandom_range(1023, 0));
            fy[0] = int'($urandom_range(1023, 0));
        end
    endtask

    task automatic run6(input bit gaps, input bit garbage);
        int cap;
        drive_frame(1'b0, 6, gaps, cap);
        finish_frame(1'b0, 6, cap, garbage);
    endtask

    task automatic run4();
        int cap;
        drive_frame(1'b1, 4, 1'b0, cap);
        finish_frame(1'b1, 4, cap, 1'b0);
    endtask

    initial begin
        int cap;
        for (int i = 0; i < 16; i++) begin
            cx[i] = 512 + int'(480.0 * $cos(6.283185307179586 * i / 16.0));
            cy[i] = 512 + int'(480.0 * $sin(6.283185307179586 * i / 16.0));
        end

        repeat (2) @(negedge clk);
        for (int id = 0; id < 3; id++) begin
            chk("rst_busy", busy_o[id], 1'b0);
            chk("rst_valid", valid_o[id], 1'b0);
            chk("rst_inside", ins_o[id], 1'b0);
            chk("rst_edge", edge_o[id], 1'b0);
        end
        @(negedge clk);
        reset = 1'b0;

        set_hex(150, 100); run6(1'b0, 1'b0);
        set_hex(150, 0);   run6(1'b0, 1'b0);
        set_hex(10, 10);   run6(1'b0, 1'b0);
        set_sq(512, 512);  run4();
        set_sq(1023, 512); run4();
        set_hex(150, 100); run6(1'b1, 1'b1);

        // Abort a frame mid-SORT; the held result must clear and no pulse follow.
        set_hex(150, 100);
        drive_frame(1'b0, 6, 1'b0, cap);
        @(negedge clk);
        iv6 = 1'b0;
        repeat (5) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        for (int id = 0; id < 2; id++) begin
            chk("arst_busy", busy_o[id], 1'b0);
            chk("arst_valid", valid_o[id], 1'b0);
            chk("arst_inside", ins_o[id], 1'b0);
        end
        @(negedge clk);
        reset = 1'b0;
        set_hex(150, 100); run6(1'b0, 1'b0);

        repeat (20) begin
            rand_poly(6);
            run6(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
        end
        repeat (10) begin
            rand_poly(4);
            run4();
        end

        repeat (30) @(negedge clk);
        for (int id = 0; id < 3; id++) begin
            total++;
            if (qsize(id) != 0) begin
                bad++;
                $display("FAIL drain dut%0d got pending=%0d want 0", id, qsize(id));
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
